// File: rtl/mpx_encoder.sv
// mpx_encoder: FM broadcast multiplex (MPX) composite generator.
// Mono sum, 19 kHz pilot, 38 kHz DSB-SC difference and RDS in 3 stages.
module mpx_encoder #(
  parameter int C_PCM_BITS = 16,
  parameter int C_CLK_HZ   = 25000000,
  parameter int C_PILOT_HZ = 19000,
  parameter int C_SIN_BITS = 8,
  parameter int C_STEREO   = 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic signed [C_PCM_BITS-1:0] pcm_l,
  input  logic signed [C_PCM_BITS-1:0] pcm_r,
  input  logic signed [C_PCM_BITS-1:0] rds_in,
  input  logic                         in_valid,
  input  logic                         stereo_en,
  output logic signed [C_PCM_BITS-1:0] mpx_out,
  output logic                         mpx_valid
);

  localparam int P    = C_PCM_BITS;
  localparam int W    = C_PCM_BITS + 3;
  localparam int S    = C_SIN_BITS;
  localparam int QN   = 1 << S;
  localparam int PEAK = (1 << (P - 1)) - 1;

  localparam logic [63:0] INC64 =
    ((64'(C_PILOT_HZ) << 32) + 64'(C_CLK_HZ / 2)) / 64'(C_CLK_HZ);
  localparam logic [31:0] INC = INC64[31:0];

  localparam logic signed [W-1:0] K7     = W'(7);
  localparam logic signed [W-1:0] SAT_HI = {4'b0000, {(P-1){1'b1}}};
  localparam logic signed [W-1:0] SAT_LO = {4'b1111, {(P-1){1'b0}}};

  logic [31:0] phase;

  // free-running pilot phase; the sample strobe never stalls it
  always_ff @(posedge clk) begin
    if (reset) phase <= '0;
    else       phase <= phase + INC;
  end

  logic signed [P:0] l_x, r_x, sum_x1, diff_x1;

  assign l_x     = pcm_l;
  assign r_x     = pcm_r;
  assign sum_x1  = (l_x + r_x) >>> 1;
  assign diff_x1 = (l_x - r_x) >>> 1;

  logic                s1_v, s1_st;
  logic signed [P-1:0] s1_sum, s1_diff, s1_rds;
  logic [S+2:0]        s1_ph;

  // stage 1: capture sample, mode and the top phase bits
  always_ff @(posedge clk) begin
    if (reset) s1_v <= 1'b0;
    else       s1_v <= in_valid;
    if (in_valid) begin
      s1_st   <= stereo_en && (C_STEREO != 0);
      s1_sum  <= sum_x1[P-1:0];
      s1_diff <= diff_x1[P-1:0];
      s1_rds  <= rds_in;
      s1_ph   <= phase[31 -: S+3];
    end
  end

  logic signed [P-1:0] dsb_c, pil_c;

  if (C_STEREO != 0) begin : g_stereo
    localparam real TWO_PI = 6.283185307179586;

    logic signed [P-1:0]   qlut [QN];
    logic [S-1:0]          a19, a38;
    logic signed [P-1:0]   m19, m38, sin19, sub38;
    logic signed [2*P-1:0] prod;

    // half-step offset makes the quadrant mirror an exact bit flip
    for (genvar k = 0; k < QN; k++) begin : g_lut
      localparam real ANG =
        TWO_PI * (real'(k) + 0.5) / real'(4 * QN);
      localparam int VAL =
        $rtoi($floor(real'(PEAK) * $sin(ANG) + 0.5));
      assign qlut[k] = VAL[P-1:0];
    end

    assign a19   = s1_ph[S+1] ? ~s1_ph[S:1] : s1_ph[S:1];
    assign a38   = s1_ph[S] ? ~s1_ph[S-1:0] : s1_ph[S-1:0];
    assign m19   = qlut[a19];
    assign m38   = qlut[a38];
    assign sin19 = s1_ph[S+2] ? -m19 : m19;
    assign sub38 = s1_ph[S+1] ? -m38 : m38;
    assign prod  = s1_diff * sub38;
    assign dsb_c = P'(prod >>> (P - 1));
    assign pil_c = sin19 >>> 3;
  end else begin : g_mono
    assign dsb_c = '0;
    assign pil_c = '0;
  end

  logic                s2_v, s2_st;
  logic signed [P-1:0] s2_sum, s2_dsb, s2_pil, s2_rds;

  // stage 2: register subcarrier product and scaled pilot
  always_ff @(posedge clk) begin
    if (reset) s2_v <= 1'b0;
    else       s2_v <= s1_v;
    if (s1_v) begin
      s2_st  <= s1_st;
      s2_sum <= s1_sum;
      s2_dsb <= dsb_c;
      s2_pil <= pil_c;
      s2_rds <= s1_rds;
    end
  end

  logic signed [W-1:0] sum_w, dsb_w, pil_w, rds_w, acc;
  logic signed [P-1:0] mpx_c;

  assign sum_w = s2_sum;
  assign dsb_w = s2_dsb;
  assign pil_w = s2_pil;
  assign rds_w = s2_rds;

  // composite mix; 14*x>>>4 is folded to 7*x>>>3 so it cannot wrap
  always_comb begin
    if (s2_st)
      acc = ((K7 * (sum_w + dsb_w)) >>> 4) + pil_w + (rds_w >>> 3);
    else
      acc = ((K7 * sum_w) >>> 3) + (rds_w >>> 3);
    mpx_c = acc[P-1:0];
    if (acc > SAT_HI) mpx_c = SAT_HI[P-1:0];
    if (acc < SAT_LO) mpx_c = SAT_LO[P-1:0];
  end

  // stage 3: output register, holds between strobes
  always_ff @(posedge clk) begin
    if (reset) begin
      mpx_valid <= 1'b0;
      mpx_out   <= '0;
    end else begin
      mpx_valid <= s2_v;
      if (s2_v) mpx_out <= mpx_c;
    end
  end

endmodule

// File: tb/tb_mpx_encoder.sv
// tb_mpx_encoder: scoreboard bench for the MPX composite encoder.
// Expected samples are modelled from the mix equations and ideal sine.
`timescale 1ns/1ps
module tb_mpx_encoder;

  localparam logic [31:0] INC = 32'd3264175;

  typedef struct {
    int val;
    int due;
  } exp_t;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic signed [15:0] pcm_l = '0;
  logic signed [15:0] pcm_r = '0;
  logic signed [15:0] rds_in = '0;
  logic               in_valid = 1'b0;
  logic               stereo_en = 1'b0;
  logic signed [15:0] mpx_out;
  logic               mpx_valid;

  exp_t               sb[$];
  int                 n_tests = 0;
  int                 n_fail = 0;
  int                 cyc = 0;
  logic [31:0]        model_ph = '0;
  logic signed [15:0] last_out = '0;

  always #10 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    model_ph <= reset ? 32'd0 : model_ph + INC;
  end

  mpx_encoder dut (
    .clk(clk),
    .reset(reset),
    .pcm_l(pcm_l),
    .pcm_r(pcm_r),
    .rds_in(rds_in),
    .in_valid(in_valid),
    .stereo_en(stereo_en),
    .mpx_out(mpx_out),
    .mpx_valid(mpx_valid)
  );

  function automatic int sin_q(input logic [31:0] ph);
    real a, v;
    a = 6.283185307179586 * (real'(ph[31:22]) + 0.5) / 1024.0;
    v = 32767.0 * $sin(a);
    return $rtoi($floor(v + 0.5));
  endfunction

  function automatic int model(input int l, input int r, input int rds,
                               input bit st, input logic [31:0] ph);
    int s, d, dsb, pil, t;
    s = (l + r) >>> 1;
    d = (l - r) >>> 1;
    if (st) begin
      dsb = (d * sin_q(ph << 1)) >>> 15;
      pil = sin_q(ph) >>> 3;
      t = ((7 * s + 7 * dsb) >>> 4) + pil + (rds >>> 3);
    end else begin
      t = ((14 * s) >>> 4) + (rds >>> 3);
    end
    if (t > 32767) t = 32767;
    if (t < -32768) t = -32768;
    return t;
  endfunction

  task automatic drive(input int l, input int r, input int rds,
                       input bit st, input bit v);
    exp_t e;
    pcm_l = 16'(l);
    pcm_r = 16'(r);
    rds_in = 16'(rds);
    stereo_en = st;
    in_valid = v;
    if (v && !reset) begin
      e.val = model(l, r, rds, st, model_ph);
      e.due = cyc + 3;
      sb.push_back(e);
    end
  endtask

  task automatic test_reset();
    exp_t e;
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      drive(1000, 2000, 300, 1'b1, 1'b1);
      n_tests++;
      if (mpx_out !== 16'sd0 || mpx_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_state: out=%0d valid=%0b, required 0/0",
                 mpx_out, mpx_valid);
      end
    end
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      if (mpx_valid) begin
        n_tests++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL reset_spurious: out=%0d, required no pulse",
                   mpx_out);
        end else begin
          e = sb.pop_front();
          if (mpx_out !== 16'(e.val) || cyc !== e.due) begin
            n_fail++;
            $display("FAIL reset_first: got %0d @%0d, required %0d @%0d",
                     mpx_out, cyc, e.val, e.due);
          end
        end
        last_out = mpx_out;
      end else begin
        n_tests++;
        if (mpx_out !== last_out) begin
          n_fail++;
          $display("FAIL reset_hold: got %0d, required %0d",
                   mpx_out, last_out);
        end
      end
      if (i == 0) begin
        reset = 1'b0;
        drive(20000, -12000, 0, 1'b1, 1'b1);
      end else begin
        drive(0, 0, 0, 1'b0, 1'b0);
      end
    end
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL reset_drain: %0d pending, required 0", sb.size());
    end
  endtask

  task automatic test_mono();
    exp_t e;
    int ls[3] = '{16384, -20000, 3};
    int rs[3] = '{16384, 8000, 0};
    int ds[3] = '{0, 800, -9};
    int fixed = model(16384, 16384, 0, 1'b0, 32'd0);
    n_tests++;
    if (fixed != 14336) begin
      n_fail++;
      $display("FAIL mono_ref: model %0d, required 14336", fixed);
    end
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      if (mpx_valid) begin
        n_tests++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL mono_spurious: out=%0d, required no pulse",
                   mpx_out);
        end else begin
          e = sb.pop_front();
          if (mpx_out !== 16'(e.val) || cyc !== e.due) begin
            n_fail++;
            $display("FAIL mono_out: got %0d @%0d, required %0d @%0d",
                     mpx_out, cyc, e.val, e.due);
          end
        end
        last_out = mpx_out;
      end else begin
        n_tests++;
        if (mpx_out !== last_out) begin
          n_fail++;
          $display("FAIL mono_hold: got %0d, required %0d",
                   mpx_out, last_out);
        end
      end
      if (i < 3) drive(ls[i], rs[i], ds[i], 1'b0, 1'b1);
      else       drive(0, 0, 0, 1'b0, 1'b0);
    end
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL mono_drain: %0d pending, required 0", sb.size());
    end
  endtask

  task automatic test_pilot();
    exp_t e;
    int pk = -40000;
    int prev = 0;
    int nx = 0;
    int x0 = 0;
    int x1 = 0;
    for (int i = 0; i < 2705; i++) begin
      @(negedge clk);
      if (mpx_valid) begin
        n_tests++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL pilot_spurious: out=%0d, required no pulse",
                   mpx_out);
        end else begin
          e = sb.pop_front();
          if (mpx_out !== 16'(e.val) || cyc !== e.due) begin
            n_fail++;
            $display("FAIL pilot_out: got %0d @%0d, required %0d @%0d",
                     mpx_out, cyc, e.val, e.due);
          end
        end
        if (int'(mpx_out) > pk) pk = int'(mpx_out);
        if (prev < 0 && mpx_out >= 0) begin
          if (nx == 0) x0 = cyc;
          if (nx == 1) x1 = cyc;
          nx++;
        end
        prev = int'(mpx_out);
        last_out = mpx_out;
      end
      if (i < 2700) drive(0, 0, 0, 1'b1, 1'b1);
      else          drive(0, 0, 0, 1'b0, 1'b0);
    end
    n_tests++;
    if (pk != 4095) begin
      n_fail++;
      $display("FAIL pilot_peak: got %0d, required 4095", pk);
    end
    n_tests++;
    if (nx < 2 || (x1 - x0) < 1315 || (x1 - x0) > 1316) begin
      n_fail++;
      $display("FAIL pilot_period: got %0d (crossings %0d), required 1315..1316",
               x1 - x0, nx);
    end
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL pilot_drain: %0d pending, required 0", sb.size());
    end
  endtask

  task automatic test_saturation();
    exp_t e;
    int ls[5] = '{32767, 32767, 32767, -32768, 32767};
    int rs[5] = '{32767, -32768, 32767, -32768, -32768};
    int ds[5] = '{32767, 0, 32767, -32768, -32768};
    bit ss[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (mpx_valid) begin
        n_tests++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL sat_spurious: out=%0d, required no pulse",
                   mpx_out);
        end else begin
          e = sb.pop_front();
          if (mpx_out !== 16'(e.val) || cyc !== e.due) begin
            n_fail++;
            $display("FAIL sat_out: got %0d @%0d, required %0d @%0d",
                     mpx_out, cyc, e.val, e.due);
          end
          n_tests++;
          if (e.val > 0 && mpx_out < 0) begin
            n_fail++;
            $display("FAIL sat_wrap: got %0d, required positive %0d",
                     mpx_out, e.val);
          end
        end
        last_out = mpx_out;
      end else begin
        n_tests++;
        if (mpx_out !== last_out) begin
          n_fail++;
          $display("FAIL sat_hold: got %0d, required %0d",
                   mpx_out, last_out);
        end
      end
      if (i < 5) drive(ls[i], rs[i], ds[i], ss[i], 1'b1);
      else       drive(0, 0, 0, 1'b0, 1'b0);
    end
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL sat_drain: %0d pending, required 0", sb.size());
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int nv = 0;
    int first = 0;
    int last = 0;
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      if (mpx_valid) begin
        n_tests++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL b2b_spurious: out=%0d, required no pulse",
                   mpx_out);
        end else begin
          e = sb.pop_front();
          if (mpx_out !== 16'(e.val) || cyc !== e.due) begin
            n_fail++;
            $display("FAIL b2b_out: got %0d @%0d, required %0d @%0d",
                     mpx_out, cyc, e.val, e.due);
          end
        end
        if (nv == 0) first = cyc;
        last = cyc;
        nv++;
        last_out = mpx_out;
      end
      if (i < 8)
        drive(int'($urandom_range(0, 65535)) - 32768,
              int'($urandom_range(0, 65535)) - 32768,
              int'($urandom_range(0, 65535)) - 32768,
              i[0], 1'b1);
      else
        drive(0, 0, 0, 1'b0, 1'b0);
    end
    n_tests++;
    if (nv != 8 || (last - first) != 7) begin
      n_fail++;
      $display("FAIL b2b_train: got %0d pulses over %0d cycles, required 8 over 7",
               nv, last - first);
    end
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL b2b_drain: %0d pending, required 0", sb.size());
    end
  endtask

  task automatic test_random();
    exp_t e;
    for (int i = 0; i < 65; i++) begin
      @(negedge clk);
      if (mpx_valid) begin
        n_tests++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL rand_spurious: out=%0d, required no pulse",
                   mpx_out);
        end else begin
          e = sb.pop_front();
          if (mpx_out !== 16'(e.val) || cyc !== e.due) begin
            n_fail++;
            $display("FAIL rand_out: got %0d @%0d, required %0d @%0d",
                     mpx_out, cyc, e.val, e.due);
          end
        end
        last_out = mpx_out;
      end else begin
        n_tests++;
        if (mpx_out !== last_out) begin
          n_fail++;
          $display("FAIL rand_hold: got %0d, required %0d",
                   mpx_out, last_out);
        end
      end
      if (i < 60)
        drive(int'($urandom_range(0, 65535)) - 32768,
              int'($urandom_range(0, 65535)) - 32768,
              int'($urandom_range(0, 65535)) - 32768,
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      else
        drive(0, 0, 0, 1'b0, 1'b0);
    end
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL rand_drain: %0d pending, required 0", sb.size());
    end
  endtask

  task automatic test_reset_midflight();
    exp_t e;
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      if (mpx_valid) begin
        n_tests++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL flush_spurious: out=%0d, required no pulse",
                   mpx_out);
        end else begin
          e = sb.pop_front();
          if (mpx_out !== 16'(e.val) || cyc !== e.due) begin
            n_fail++;
            $display("FAIL flush_out: got %0d @%0d, required %0d @%0d",
                     mpx_out, cyc, e.val, e.due);
          end
        end
        last_out = mpx_out;
      end else begin
        n_tests++;
        if (mpx_out !== last_out) begin
          n_fail++;
          $display("FAIL flush_hold: got %0d, required %0d",
                   mpx_out, last_out);
        end
      end
      if (i == 0) begin
        drive(12000, 4000, 100, 1'b0, 1'b1);
      end else if (i == 1) begin
        reset = 1'b1;
        sb.delete();
        last_out = '0;
        drive(0, 0, 0, 1'b0, 1'b0);
      end else if (i == 2) begin
        drive(9000, 9000, 0, 1'b0, 1'b1);
      end else if (i == 3) begin
        reset = 1'b0;
        drive(0, 0, 0, 1'b0, 1'b0);
      end else begin
        drive(0, 0, 0, 1'b0, 1'b0);
      end
    end
    n_tests++;
    if (mpx_out !== 16'sd0 || sb.size() != 0) begin
      n_fail++;
      $display("FAIL flush_state: out=%0d pending=%0d, required 0/0",
               mpx_out, sb.size());
    end
  endtask

  initial begin
    test_reset();
    test_mono();
    test_pilot();
    test_saturation();
    test_back_to_back();
    test_random();
    test_reset_midflight();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
